// File: rtl/led_step_ctrl_if.sv
// Button inputs and step-control outputs between the control stage and its
// environment (buttons on one side, the LED rotator on the other).
interface led_step_ctrl_if;
  logic       key_run;
  logic       key_speed;
  logic       key_dir;
  logic       run;
  logic       dir;
  logic [1:0] speed;
  logic       tick;
  logic       clk_step;

  modport master (
    output key_run, key_speed, key_dir,
    input  run, dir, speed, tick, clk_step
  );

  modport slave (
    input  key_run, key_speed, key_dir,
    output run, dir, speed, tick, clk_step
  );
endinterface

// File: rtl/led_step_ctrl.sv
// Button debounce plus run/direction/speed state and step timing for the
// 8-LED rotator: one-cycle tick enable and a 50 % duty step clock.
module key_db #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1, s2, lvl;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      lvl   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        // level accepted; only the falling (pressed) transition pulses
        lvl   <= s2;
        cnt   <= '0;
        press <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module led_step_ctrl #(
  parameter int unsigned DB_CYCLES = 1000000,
  parameter int unsigned BASE_DIV  = 50000000
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  led_step_ctrl_if.slave   bus
);
  localparam int NKEY = 3;

  logic [NKEY-1:0] raw;
  logic [NKEY-1:0] press;
  logic            run_q, dir_q, tick_q, cs_q;
  logic [1:0]      speed_q;
  logic [31:0]     tcnt;
  logic [31:0]     period;

  // bit 0 run, bit 1 speed, bit 2 dir
  assign raw = {bus.key_dir, bus.key_speed, bus.key_run};

  for (genvar k = 0; k < NKEY; k++) begin : g_db
    key_db #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk_50mhz),
      .rst   (rst),
      .raw   (raw[k]),
      .press (press[k])
    );
  end

  assign period = 32'(BASE_DIV) >> speed_q;

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b0;
      dir_q   <= 1'b0;
      speed_q <= 2'd0;
      tick_q  <= 1'b0;
      cs_q    <= 1'b0;
      tcnt    <= '0;
    end else begin
      tick_q <= 1'b0;
      if (press[0]) run_q <= ~run_q;
      if (press[2]) dir_q <= ~dir_q;
      // a speed change restarts the period and suppresses a coincident tick
      if (press[1]) begin
        speed_q <= speed_q + 2'd1;
        tcnt    <= '0;
      end else if (run_q) begin
        if (tcnt == period - 32'd1) begin
          tick_q <= 1'b1;
          tcnt   <= '0;
          cs_q   <= ~cs_q;
        end else begin
          tcnt <= tcnt + 32'd1;
        end
      end
    end
  end

  assign bus.run      = run_q;
  assign bus.dir      = dir_q;
  assign bus.speed    = speed_q;
  assign bus.tick     = tick_q;
  assign bus.clk_step = cs_q;
endmodule

// File: tb/tb_led_step_ctrl.sv
// Scoreboard bench for led_step_ctrl (DB_CYCLES=4, BASE_DIV=16): stimulus
// queues timestamped output events, a negedge monitor pops and compares them.
module tb_led_step_ctrl;
  localparam int K_RUN = 0, K_DIR = 1, K_SPD = 2, K_TICK = 3;
  localparam int NEV = 42;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];

  // {kind, cycle offset from run-on edge, value}; tick value is clk_step level
  int tab [NEV][3] = '{
    '{K_RUN,0,1},
    '{K_TICK,16,1}, '{K_TICK,32,0}, '{K_TICK,48,1},
    '{K_SPD,57,1}, '{K_TICK,65,0}, '{K_TICK,73,1},
    '{K_SPD,81,2}, '{K_TICK,85,0}, '{K_TICK,89,1}, '{K_TICK,93,0},
    '{K_TICK,97,1}, '{K_TICK,101,0},
    '{K_SPD,105,3}, '{K_TICK,107,1}, '{K_TICK,109,0}, '{K_TICK,111,1},
    '{K_TICK,113,0}, '{K_TICK,115,1}, '{K_TICK,117,0}, '{K_TICK,119,1},
    '{K_TICK,121,0}, '{K_TICK,123,1}, '{K_TICK,125,0}, '{K_TICK,127,1},
    '{K_SPD,129,0}, '{K_TICK,145,0}, '{K_TICK,161,1},
    '{K_RUN,172,0}, '{K_RUN,197,1}, '{K_TICK,202,0}, '{K_TICK,218,1},
    '{K_RUN,232,0}, '{K_DIR,232,1},
    '{K_RUN,257,1}, '{K_TICK,259,0}, '{K_SPD,267,1}, '{K_TICK,275,1},
    '{K_TICK,283,0}, '{K_SPD,291,2}, '{K_TICK,295,1}, '{K_TICK,299,0}
  };

  led_step_ctrl_if bus ();

  led_step_ctrl #(.DB_CYCLES(4), .BASE_DIV(16)) dut (
    .clk_50mhz (clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind %0d value %0d at cycle %0d, none expected",
               kind, val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        errors++;
        $display("FAIL event: got kind %0d val %0d cyc %0d, expected kind %0d val %0d cyc %0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // monitor
  logic       p_run = 1'b0, p_dir = 1'b0, p_cs = 1'b0;
  logic [1:0] p_spd = 2'd0;
  always @(negedge clk) begin
    if (rst) begin
      p_run = 1'b0; p_dir = 1'b0; p_cs = 1'b0; p_spd = 2'd0;
    end else begin
      if (bus.run != p_run) observe(K_RUN, int'(bus.run));
      if (bus.dir != p_dir) observe(K_DIR, int'(bus.dir));
      if (bus.speed != p_spd) observe(K_SPD, int'(bus.speed));
      if (bus.tick) observe(K_TICK, int'(bus.clk_step));
      else if (bus.clk_step != p_cs) chk("clk_step_without_tick", int'(bus.clk_step), int'(p_cs));
      p_run = bus.run; p_dir = bus.dir; p_cs = bus.clk_step; p_spd = bus.speed;
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // mask: 1 run, 2 speed, 4 dir; keys go low at cycle 'at' for 8 cycles
  task automatic press(input int mask, input int at);
    wait_until(at);
    if (mask[0]) bus.key_run = 1'b0;
    if (mask[1]) bus.key_speed = 1'b0;
    if (mask[2]) bus.key_dir = 1'b0;
    repeat (8) @(negedge clk);
    bus.key_run = 1'b1; bus.key_speed = 1'b1; bus.key_dir = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_run"}, int'(bus.run), 0);
    chk({tag, "_dir"}, int'(bus.dir), 0);
    chk({tag, "_speed"}, int'(bus.speed), 0);
    chk({tag, "_tick"}, int'(bus.tick), 0);
    chk({tag, "_clk_step"}, int'(bus.clk_step), 0);
  endtask

  initial begin
    int r, c1;
    bus.key_run = 1'b1; bus.key_speed = 1'b1; bus.key_dir = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    r = cyc + 7;
    for (int i = 0; i < NEV; i++) q.push_back('{tab[i][0], r + tab[i][1], tab[i][2]});
    press(1, cyc);

    // glitch shorter than the debounce window
    wait_until(r + 33);
    bus.key_speed = 1'b0;
    repeat (3) @(negedge clk);
    bus.key_speed = 1'b1;

    press(2, r + 50);
    press(2, r + 74);
    press(2, r + 98);
    press(2, r + 122);
    press(1, r + 165);
    press(1, r + 190);
    press(5, r + 225);
    // released keys must not produce events in the gap
    press(1, r + 250);
    press(2, r + 260);
    press(2, r + 284);

    // reset lands mid-debounce of key_run and mid-count at speed 2
    wait_until(r + 300);
    bus.key_run = 1'b0;
    wait_until(r + 302);
    #2 rst = 1'b1;
    #1 chk_zero("async_reset");
    chk("queue_drained_before_reset", q.size(), 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    c1 = cyc;
    q.push_back('{K_RUN, c1 + 7, 1});
    q.push_back('{K_TICK, c1 + 23, 1});
    repeat (10) @(negedge clk);
    bus.key_run = 1'b1;
    wait_until(c1 + 30);
    chk("queue_drained_at_end", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_step_ctrl.md
Name: led_step_ctrl

Overview:
- Front-end control stage that directly feeds the 8-LED rotator.
- Debounces three raw push-buttons and keeps run, direction and speed state.
- Generates the rotator's step timing as two outputs: a one-cycle `tick` enable and a square-wave `clk_step`.
- `clk_step` can drive a posedge-clocked rotator unchanged.

Parameters:
- DB_CYCLES, 1000000: consecutive stable cycles needed to accept a key level (20 ms at 50 MHz).
- BASE_DIV, 50000000: tick period in cycles at speed 0 (1 Hz). Must be ≥8 and divisible by 8.

Ports:
- clk_50mhz  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- key_run  input  1  raw button, active-low; each press toggles run.
- key_speed  input  1  raw button, active-low; each press steps speed.
- key_dir  input  1  raw button, active-low; each press toggles dir.
- run  output  1  1 = stepping enabled.
- dir  output  1  0 = rotate left (toward bit 7), 1 = rotate right.
- speed  output  2  rate select: tick period = BASE_DIV >> speed (1/2/4/8 Hz by default).
- tick  output  1  one-cycle step pulse.
- clk_step  output  1  toggles on every tick; 50 % duty step clock for the rotator.

Behaviour:
- Reset (async, while rst=1):
  - run=0, dir=0, speed=0, tick=0, clk_step=0.
  - All counters = 0.
  - Synchronizer flops and debounced levels = 1 (released).
- Release of rst takes effect at the next rising edge. Reset mid-count discards all progress, including partial debounce.
- Per key, identical and independent:
  - 2-flop synchronizer.
  - Debounce counter counts while the synchronized level differs from the debounced level. It clears to 0 on any cycle they match.
  - When the counter would reach DB_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - A 1→0 debounced transition is a press and gives a one-cycle internal pulse. The 0→1 release gives no pulse.
  - Glitches shorter than DB_CYCLES are ignored.
- Latency: for a raw low held from edge 0, the corresponding state output changes at edge DB_CYCLES+3. This is exact and the bench checks it.
- Press actions (registered):
  - Run press: run ← ~run.
  - Dir press: dir ← ~dir.
  - Speed press: speed ← speed+1 mod 4 (3 wraps to 0). The tick counter clears to 0 in the same cycle and no tick is issued that cycle.
  - Simultaneous presses on different keys each take effect in the same cycle.
- Tick generator:
  - 32-bit counter `tcnt` advances only while run=1.
  - When run=1 and tcnt = (BASE_DIV>>speed)−1: tick=1 for that cycle only, tcnt ← 0, clk_step ← ~clk_step.
  - Otherwise tick=0.
- Pause and resume:
  - While run=0, tcnt holds its value and clk_step holds its level.
  - Resuming continues from the held count, so the first tick after resume arrives after the remaining cycles.
- A run press in the same cycle as a tick boundary: the decision uses the pre-edge run value.
  - Run was 1: the tick fires and run goes 0.
  - Run was 0: no tick; counting starts on the next cycle.
- Speed press coinciding with a tick boundary: the speed press wins. Counter clears and no tick is issued.
- Steady state: tick spacing is exactly BASE_DIV>>speed cycles. clk_step period is twice that.

Test Plan (DB_CYCLES=4, BASE_DIV=16):
- Reset → all outputs 0. key_run held low from edge 0 → run=1 at edge 7. First tick 16 cycles later, then every 16 cycles. clk_step toggles at each tick.
- key_speed pulsed low for 3 cycles (less than DB_CYCLES) → speed stays 0. Four valid presses → speed 1,2,3,0. Tick spacing at those speeds = 8, 4, 2, 16 cycles.
- run=1 with tcnt=10 → run press → tcnt frozen at its value, no ticks, clk_step stable. Second run press → next tick after the remaining cycles (16−10 minus elapsed), not 16.
- Speed press landing on the tick-boundary cycle → no tick that cycle, tcnt=0, next tick after the new period.
- key_dir and key_run pressed on the same edge → dir and run both toggle at edge 7. Release (key high for more than 4 cycles) → no state change.
- rst asserted mid-debounce and mid-count with run=1, speed=2 → all outputs 0 immediately (asynchronous). After release, a new press needs the full DB_CYCLES+3 edges.
